// File: rtl/ctrl_pkg.sv
// Shared types for the multi-channel upsampling controller: state encoding
// and the Moore output bundle decoded from each state.
package ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PTR_REQ   = 3'b000,
        CALC_INIT = 3'b001,
        CALC      = 3'b011,
        DRAIN     = 3'b010,
        LOAD      = 3'b110,
        PROG      = 3'b100
    } ctrl_state_t;

    typedef struct packed {
        logic en_fetch;
        logic ptrs_req;
        logic ringbuf_addr_clr;
        logic en_init;
        logic mac_init;
        logic ringbuf_init;
        logic regf_rd;
        logic wea;
        logic ena;
        logic enb;
        logic en_calc;
        logic count;
        logic regf_en;
        logic en_load;
        logic res_valid;
        logic web;
        logic prog_ack;
        logic busy;
    } ctrl_out_t;

    // Moore output decode; unknown encodings drive everything low.
    function automatic ctrl_out_t ctrl_decode(input ctrl_state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            PTR_REQ: begin
                o.en_fetch         = 1'b1;
                o.ptrs_req         = 1'b1;
                o.ringbuf_addr_clr = 1'b1;
            end
            CALC_INIT: begin
                o.en_init      = 1'b1;
                o.mac_init     = 1'b1;
                o.ringbuf_init = 1'b1;
                o.regf_rd      = 1'b1;
                o.wea          = 1'b1;
                o.ena          = 1'b1;
                o.enb          = 1'b1;
                o.regf_en      = 1'b1;
                o.busy         = 1'b1;
            end
            CALC: begin
                o.ena     = 1'b1;
                o.enb     = 1'b1;
                o.en_calc = 1'b1;
                o.count   = 1'b1;
                o.busy    = 1'b1;
            end
            DRAIN: begin
                o.busy = 1'b1;
            end
            LOAD: begin
                o.regf_en   = 1'b1;
                o.en_load   = 1'b1;
                o.res_valid = 1'b1;
                o.busy      = 1'b1;
            end
            PROG: begin
                o.enb      = 1'b1;
                o.web      = 1'b1;
                o.prog_ack = 1'b1;
                o.busy     = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_step_cnt.sv
// Up-counter with synchronous clear, increment and an equality hit flag
// against a run-time limit; freezes when en is low.
module ctrl_step_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         hit
);

    // Count register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && clr) begin
            cnt <= '0;
        end else if (en && inc) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/ctrl_fsm_mch.sv
// Multi-channel controller: pointer fetch, init, tap-counted convolution,
// MAC drain and handshaked result load per channel, plus coefficient load.
module ctrl_fsm_mch
    import ctrl_pkg::*;
#(
    parameter  int NCH     = 2,
    parameter  int TAPS_W  = 8,
    parameter  int MAC_LAT = 2,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_complete,
    input  logic              iw_valid,
    input  logic [TAPS_W-1:0] taps,
    input  logic              prog_req,
    input  logic              prog_done,
    input  logic              res_ready,
    output logic              en_fetch,
    output logic              ptrs_req,
    output logic              ringbuf_addr_clr,
    output logic              en_init,
    output logic              mac_init,
    output logic              ringbuf_init,
    output logic              regf_rd,
    output logic              wea,
    output logic              ena,
    output logic              enb,
    output logic              en_calc,
    output logic              count,
    output logic              regf_en,
    output logic              en_load,
    output logic              res_valid,
    output logic              regf_wr,
    output logic              web,
    output logic              prog_ack,
    output logic [CH_W-1:0]   ch_idx,
    output logic [TAPS_W-1:0] tap_idx,
    output logic              busy
);

    ctrl_state_t       state_r;
    ctrl_state_t       state_s;
    ctrl_out_t         out_r;
    logic [TAPS_W-1:0] taps_q_r;
    logic [CH_W-1:0]   ch_r;
    logic [TAPS_W-1:0] tap_cnt_s;
    logic [3:0]        lat_cnt_s;
    logic              tap_hit_s;
    logic              lat_hit_s;
    logic              ptr_hs_s;
    logic              last_ch_s;

    assign ptr_hs_s  = req_complete & iw_valid;
    assign last_ch_s = (ch_r == CH_W'(NCH - 1));

    ctrl_step_cnt #(.W(TAPS_W)) u_tap_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (state_r == CALC_INIT),
        .inc   ((state_r == CALC) && !tap_hit_s),
        .limit (taps_q_r),
        .cnt   (tap_cnt_s),
        .hit   (tap_hit_s)
    );

    // Drain counter is re-armed on every CALC cycle so DRAIN always starts at 0.
    ctrl_step_cnt #(.W(4)) u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (state_r == CALC),
        .inc   ((state_r == DRAIN) && !lat_hit_s),
        .limit (4'(MAC_LAT - 1)),
        .cnt   (lat_cnt_s),
        .hit   (lat_hit_s)
    );

    // Next-state logic; a pending coefficient load beats the pointer handshake.
    always_comb begin
        state_s = state_r;
        if (en) begin
            case (state_r)
                PTR_REQ: begin
                    if (prog_req) begin
                        state_s = PROG;
                    end else if (ptr_hs_s) begin
                        state_s = CALC_INIT;
                    end else begin
                        state_s = PTR_REQ;
                    end
                end
                CALC_INIT: begin
                    state_s = CALC;
                end
                CALC: begin
                    state_s = tap_hit_s ? DRAIN : CALC;
                end
                DRAIN: begin
                    state_s = lat_hit_s ? LOAD : DRAIN;
                end
                LOAD: begin
                    if (res_ready) begin
                        state_s = last_ch_s ? PTR_REQ : CALC_INIT;
                    end else begin
                        state_s = LOAD;
                    end
                end
                PROG: begin
                    state_s = prog_done ? PTR_REQ : PROG;
                end
                default: begin
                    state_s = PTR_REQ;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= PTR_REQ;
            out_r   <= ctrl_decode(PTR_REQ);
        end else begin
            state_r <= state_s;
            out_r   <= ctrl_decode(state_s);
        end
    end

    // Tap limit capture and channel sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q_r <= '0;
            ch_r     <= '0;
        end else if (en && (state_r == PTR_REQ) && !prog_req && ptr_hs_s) begin
            taps_q_r <= taps;
            ch_r     <= '0;
        end else if (en && (state_r == LOAD) && res_ready && !last_ch_s) begin
            taps_q_r <= taps_q_r;
            ch_r     <= ch_r + CH_W'(1);
        end else begin
            taps_q_r <= taps_q_r;
            ch_r     <= ch_r;
        end
    end

    assign en_fetch         = out_r.en_fetch;
    assign ptrs_req         = out_r.ptrs_req;
    assign ringbuf_addr_clr = out_r.ringbuf_addr_clr;
    assign en_init          = out_r.en_init;
    assign mac_init         = out_r.mac_init;
    assign ringbuf_init     = out_r.ringbuf_init;
    assign regf_rd          = out_r.regf_rd;
    assign wea              = out_r.wea;
    assign ena              = out_r.ena;
    assign enb              = out_r.enb;
    assign en_calc          = out_r.en_calc;
    assign count            = out_r.count;
    assign regf_en          = out_r.regf_en;
    assign en_load          = out_r.en_load;
    assign res_valid        = out_r.res_valid;
    assign web              = out_r.web;
    assign prog_ack         = out_r.prog_ack;
    assign busy             = out_r.busy;
    // Single write strobe: only on the enabled handshake cycle, never under reset.
    assign regf_wr          = (state_r == LOAD) & res_ready & en & ~rst;
    assign ch_idx           = ch_r;
    assign tap_idx          = tap_cnt_s;

endmodule
